seg_display_arbiter: RTL and testbench

//   Shares the single 8-digit hex_display between three requesters: 0=mode status (seg_driver),
//   1=pen/colour readout, 2=alert. Fixed priority 2>1>0, minimum-hold anti-flicker, one blank

---
 rtl/seg_display_arbiter_pkg.sv | 35 +++
 rtl/seg_blink_timer.sv | 32 +++
 rtl/seg_display_arbiter.sv | 93 +++++++++
 tb/tb_seg_display_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the hex display arbiter: FSM states, blink phase and source indices.
package seg_display_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SWITCH,
    ARB_GRANT
  } arb_state_t;

  typedef enum logic {
    PHASE_VISIBLE,
    PHASE_HIDDEN
  } blink_phase_t;

  localparam logic [1:0] SRC_STATUS = 2'd0;
  localparam logic [1:0] SRC_PEN    = 2'd1;
  localparam logic [1:0] SRC_ALERT  = 2'd2;

  // Highest-index asserted request; returns SRC_STATUS when nothing is requested.
  function automatic logic [1:0] top_src(input logic [2:0] req);
    if (req[SRC_ALERT])    return SRC_ALERT;
    else if (req[SRC_PEN]) return SRC_PEN;
    else                   return SRC_STATUS;
  endfunction

  // Request bits that outrank the given source.
  function automatic logic [2:0] above_mask(input logic [1:0] src);
    case (src)
      SRC_STATUS: return 3'b110;
      SRC_PEN:    return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// Blink half-period counter: toggles the phase every BLINK_CYC cycles, held visible while cleared.
module seg_blink_timer
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned BLINK_CYC = 12_500_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  output blink_phase_t phase
);

  localparam int unsigned CNT_W = $clog2(BLINK_CYC + 1);

  logic [CNT_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= PHASE_VISIBLE;
    end else if (clear) begin
      blink_cnt <= '0;
      phase     <= PHASE_VISIBLE;
    end else if (blink_cnt == CNT_W'(BLINK_CYC - 1)) begin
      blink_cnt <= '0;
      phase     <= (phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 8-digit hex display between three prioritised sources with hold time,
// a blank cycle on every owner change and optional per-source blink.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYC  = 25_000_000,
  parameter int unsigned BLINK_CYC = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [95:0] src_data,
  input  logic [23:0] src_en,
  input  logic [2:0]  src_blink,
  output logic [2:0]  grant,
  output logic [31:0] disp_data,
  output logic [7:0]  disp_en,
  output logic        busy
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

  arb_state_t       state, state_next;
  logic [1:0]       owner;
  logic [1:0]       win;
  logic [HOLD_W-1:0] hold_cnt;
  logic             hold_done;
  logic             blink_clear;
  blink_phase_t     phase;
  logic [31:0]      sel_data;
  logic [7:0]       sel_en;

  assign blink_clear = (state != ARB_GRANT);
  assign busy        = (state != ARB_IDLE);

  seg_blink_timer #(
    .BLINK_CYC(BLINK_CYC)
  ) u_blink (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(blink_clear),
    .phase(phase)
  );

  always_comb begin
    state_next = state;
    win        = top_src(req);
    hold_done  = (hold_cnt == HOLD_W'(HOLD_CYC));
    sel_data   = src_data[{owner, 5'd0} +: 32];
    sel_en     = (src_blink[owner] && phase == PHASE_HIDDEN) ? '0 : src_en[{owner, 3'd0} +: 8];
    case (state)
      ARB_IDLE:   if (|req) state_next = ARB_SWITCH;
      ARB_SWITCH: state_next = (|req) ? ARB_GRANT : ARB_IDLE;
      ARB_GRANT:  if (!req[owner] || ((|(req & above_mask(owner))) && hold_done))
                    state_next = ARB_SWITCH;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // The display loads only on cycles that stay in GRANT, so the exit edge already blanks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner     <= SRC_STATUS;
      grant     <= '0;
      hold_cnt  <= '0;
      disp_data <= '0;
      disp_en   <= '0;
    end else begin
      state <= state_next;

      if (state == ARB_SWITCH && state_next == ARB_GRANT) begin
        owner <= win;
        grant <= 3'b001 << win;
      end else if (state_next != ARB_GRANT) begin
        grant <= '0;
      end

      if (state != ARB_GRANT)
        hold_cnt <= '0;
      else if (!hold_done)
        hold_cnt <= hold_cnt + 1'b1;

      if (state == ARB_GRANT && state_next == ARB_GRANT) begin
        disp_data <= sel_data;
        disp_en   <= sel_en;
      end else begin
        disp_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_seg_display_arbiter;

  localparam int unsigned HOLD  = 8;
  localparam int unsigned BLINK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [95:0] src_data;
  logic [23:0] src_en;
  logic [2:0]  src_blink;
  logic [2:0]  grant;
  logic [31:0] disp_data;
  logic [7:0]  disp_en;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // Model: 0 = idle, 1 = blank changeover, 2 = showing owner; age = cycles shown so far.
  int          m_mode;
  int          m_owner;
  int          m_age;
  logic [31:0] m_data;
  logic [7:0]  m_en;

  always #5 clk = ~clk;

  seg_display_arbiter #(
    .HOLD_CYC (HOLD),
    .BLINK_CYC(BLINK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .src_data (src_data),
    .src_en   (src_en),
    .src_blink(src_blink),
    .grant    (grant),
    .disp_data(disp_data),
    .disp_en  (disp_en),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_owner = 0;
    m_age   = 0;
    m_data  = '0;
    m_en    = '0;
  endtask

  task automatic model_edge();
    int higher;
    higher = 0;
    for (int i = m_owner + 1; i < 3; i++) if (req[i]) higher = 1;
    case (m_mode)
      0: begin
        m_en = '0;
        if (req != 0) m_mode = 1;
      end
      1: begin
        m_en = '0;
        if (req == 0) m_mode = 0;
        else begin
          for (int i = 0; i < 3; i++) if (req[i]) m_owner = i;
          m_age  = 0;
          m_mode = 2;
        end
      end
      default: begin
        if (!req[m_owner] || (higher != 0 && m_age >= int'(HOLD))) begin
          m_mode = 1;
          m_en   = '0;
        end else begin
          m_data = src_data[32*m_owner +: 32];
          if (src_blink[m_owner] && ((m_age / int'(BLINK)) % 2 == 1)) m_en = '0;
          else m_en = src_en[8*m_owner +: 8];
          m_age++;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [2:0] exp_grant;
    exp_grant = (m_mode == 2) ? (3'b001 << m_owner) : 3'b000;
    check("grant", 32'(grant), 32'(exp_grant));
    check("busy", 32'(busy), (m_mode != 0) ? 32'd1 : 32'd0);
    check("disp_en", 32'(disp_en), 32'(m_en));
    check("disp_data", disp_data, m_data);
  endtask

  // Called at a negedge: drive req, let one rising edge happen, compare on the next negedge.
  task automatic step(input logic [2:0] r);
    req = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req       = '0;
    src_data  = '0;
    src_en    = '0;
    src_blink = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // First grant latency for the status source.
    src_data = {64'h0, 32'h1000_0000};
    src_en   = {16'h0, 8'h80};
    step(3'b001);
    check("t1_busy_switch", 32'(busy), 32'd1);
    step(3'b001);
    check("t1_grant", 32'(grant), 32'd1);
    step(3'b001);
    check("t1_disp_data", disp_data, 32'h1000_0000);
    check("t1_disp_en", 32'(disp_en), 32'h80);

    // Alert request waits for the hold time to expire.
    step(3'b001);
    step(3'b001);
    n = 0;
    do begin
      step(3'b101);
      n++;
    end while (grant != 3'b000 && n < 20);
    check("t2_hold_wait", 32'(n), 32'd6);
    step(3'b101);
    check("t2_grant_alert", 32'(grant), 32'b100);

    // Owner drop switches at once, without hold.
    step(3'b101);
    step(3'b001);
    check("t3_drop_blank", 32'(grant), 32'd0);
    step(3'b001);
    check("t3_grant_status", 32'(grant), 32'd1);

    // Pen source with blink.
    src_blink = 3'b010;
    src_en    = {8'h00, 8'hFF, 8'h80};
    step(3'b010);
    step(3'b010);
    check("t4_grant_pen", 32'(grant), 32'b010);
    for (int i = 0; i < 16; i++) begin
      step(3'b010);
      check("t4_blink", 32'(disp_en), ((i / 4) % 2 == 0) ? 32'hFF : 32'h00);
    end
    src_blink = '0;

    // Release to idle, then all requests at once.
    step(3'b000);
    check("t5_blank_en", 32'(disp_en), 32'd0);
    step(3'b000);
    check("t5_idle_busy", 32'(busy), 32'd0);
    step(3'b111);
    step(3'b111);
    check("t5_grant_alert", 32'(grant), 32'b100);
    step(3'b111);
    step(3'b111);

    // Asynchronous reset in the middle of a grant.
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_en", 32'(disp_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Random traffic; requests change rarely so holds and blinks get exercised.
    for (int c = 0; c < 600; c++) begin
      logic [2:0] r;
      r = req;
      if ($urandom_range(7) == 0) r = 3'($urandom);
      if ($urandom_range(15) == 0) src_blink = 3'($urandom);
      src_data = {$urandom, $urandom, $urandom};
      src_en   = 24'($urandom);
      step(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
